// File: rtl/add_sub_unit_if.sv
// Operand/result bundle for add_sub_unit. The master drives the operands and
// the mode bit; the slave returns the registered result and flags.
interface add_sub_unit_if #(
  parameter int WIDTH = 4
);
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             sub;
  logic [WIDTH-1:0] ans;
  logic             cy_br_out;
  logic             ovf;

  modport master (
    output a, b, sub,
    input  ans, cy_br_out, ovf
  );

  modport slave (
    input  a, b, sub,
    output ans, cy_br_out, ovf
  );
endinterface

// File: rtl/add_sub_unit.sv
// Registered two's-complement adder/subtractor built on a ripple-carry chain.
// Carry out becomes a true borrow when subtracting; OVF flags signed overflow.
module add_sub_unit #(
  parameter int WIDTH = 4
) (
  input  logic           clk_i,
  input  logic           rst_ni,
  add_sub_unit_if.slave  bus
);

  logic [WIDTH:0]   carry;
  logic [WIDTH-1:0] bInv;
  logic [WIDTH-1:0] ans_d, ans_q;
  logic             cy_d, cy_q;
  logic             ovf_d, ovf_q;

  // Subtraction is A + ~B + 1: invert B and inject SUB as the bit-0 carry-in.
  always_comb begin
    carry    = '0;
    bInv     = '0;
    ans_d    = '0;
    carry[0] = bus.sub;
    for (int i = 0; i < WIDTH; i++) begin
      bInv[i]    = bus.b[i] ^ bus.sub;
      ans_d[i]   = bus.a[i] ^ bInv[i] ^ carry[i];
      carry[i+1] = (bus.a[i] & bInv[i]) | (carry[i] & (bus.a[i] ^ bInv[i]));
    end
    cy_d  = carry[WIDTH] ^ bus.sub;
    ovf_d = carry[WIDTH] ^ carry[WIDTH-1];
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ans_q <= '0;
      cy_q  <= 1'b0;
      ovf_q <= 1'b0;
    end else begin
      ans_q <= ans_d;
      cy_q  <= cy_d;
      ovf_q <= ovf_d;
    end
  end

  assign bus.ans       = ans_q;
  assign bus.cy_br_out = cy_q;
  assign bus.ovf       = ovf_q;

endmodule

// File: tb/tb_add_sub_unit.sv
// Directed and exhaustive checks of add_sub_unit at WIDTH = 4, including
// asynchronous reset behaviour and back-to-back single-cycle latency.
module tb_add_sub_unit;

  logic clk;
  logic rstN;
  int   total;
  int   bad;

  add_sub_unit_if #(.WIDTH(4)) bus ();

  add_sub_unit #(.WIDTH(4)) dut (
    .clk_i  (clk),
    .rst_ni (rstN),
    .bus    (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Directed vectors packed as {a, b, sub, ans, cy, ovf}, all hand-computed.
  function automatic logic [14:0] getVec(input int idx);
    case (idx)
      0:       getVec = {4'h0, 4'h0, 1'b0, 4'h0, 1'b0, 1'b0};
      1:       getVec = {4'h0, 4'h1, 1'b0, 4'h1, 1'b0, 1'b0};
      2:       getVec = {4'h0, 4'h7, 1'b0, 4'h7, 1'b0, 1'b0};
      3:       getVec = {4'h7, 4'h7, 1'b0, 4'hE, 1'b0, 1'b1};
      4:       getVec = {4'h7, 4'hF, 1'b0, 4'h6, 1'b1, 1'b0};
      5:       getVec = {4'h7, 4'h8, 1'b0, 4'hF, 1'b0, 1'b0};
      6:       getVec = {4'h9, 4'h8, 1'b1, 4'h1, 1'b0, 1'b0};
      7:       getVec = {4'h9, 4'h1, 1'b1, 4'h8, 1'b0, 1'b0};
      8:       getVec = {4'h9, 4'h7, 1'b1, 4'h2, 1'b0, 1'b1};
      9:       getVec = {4'h0, 4'h7, 1'b1, 4'h9, 1'b1, 1'b0};
      10:      getVec = {4'h0, 4'hF, 1'b1, 4'h1, 1'b1, 1'b0};
      default: getVec = {4'h0, 4'h8, 1'b1, 4'h8, 1'b1, 1'b1};
    endcase
  endfunction

  // Arithmetic reference in integers: unsigned compare for carry/borrow,
  // signed range check for overflow. Returns {ans, cy, ovf}.
  function automatic logic [5:0] refModel(input logic [3:0] a, input logic [3:0] b,
                                          input logic s);
    int ua, ub, sa, sb, r, u;
    logic [3:0] ansV;
    logic cyV, ovfV;
    ua = int'(a);
    ub = int'(b);
    sa = (ua >= 8) ? ua - 16 : ua;
    sb = (ub >= 8) ? ub - 16 : ub;
    if (s) begin
      u   = ua - ub;
      cyV = (ua < ub);
      r   = sa - sb;
    end else begin
      u   = ua + ub;
      cyV = (u > 15);
      r   = sa + sb;
    end
    ansV = 4'(u & 15);
    ovfV = (r > 7) || (r < -8);
    refModel = {ansV, cyV, ovfV};
  endfunction

  task automatic applyStimulus(input logic [3:0] a, input logic [3:0] b, input logic s);
    bus.a   = a;
    bus.b   = b;
    bus.sub = s;
  endtask

  task automatic test_reset();
    rstN = 1'b0;
    applyStimulus(4'h7, 4'h7, 1'b0);
    #2;
    for (int k = 0; k < 2; k++) begin
      total++;
      if (bus.ans !== 4'h0) begin
        bad++;
        $display("[TB] FAIL reset_ans pass%0d got %h want 0", k, bus.ans);
      end
      total++;
      if (bus.cy_br_out !== 1'b0) begin
        bad++;
        $display("[TB] FAIL reset_cy pass%0d got %b want 0", k, bus.cy_br_out);
      end
      total++;
      if (bus.ovf !== 1'b0) begin
        bad++;
        $display("[TB] FAIL reset_ovf pass%0d got %b want 0", k, bus.ovf);
      end
      @(posedge clk);
      #1;
    end
    @(negedge clk);
    rstN = 1'b1;
    @(posedge clk);
    #1;
    total++;
    if (bus.ans !== 4'hE || bus.ovf !== 1'b1 || bus.cy_br_out !== 1'b0) begin
      bad++;
      $display("[TB] FAIL reset_first got ans=%h cy=%b ovf=%b want ans=e cy=0 ovf=1",
               bus.ans, bus.cy_br_out, bus.ovf);
    end
  endtask

  task automatic test_async_reset();
    @(negedge clk);
    applyStimulus(4'h7, 4'hF, 1'b0);
    @(posedge clk);
    #2;
    total++;
    if (bus.ans !== 4'h6 || bus.cy_br_out !== 1'b1) begin
      bad++;
      $display("[TB] FAIL async_pre got ans=%h cy=%b want ans=6 cy=1", bus.ans, bus.cy_br_out);
    end
    rstN = 1'b0;
    #1;
    total++;
    if (bus.ans !== 4'h0 || bus.cy_br_out !== 1'b0 || bus.ovf !== 1'b0) begin
      bad++;
      $display("[TB] FAIL async_clear got ans=%h cy=%b ovf=%b want all 0",
               bus.ans, bus.cy_br_out, bus.ovf);
    end
    applyStimulus(4'h9, 4'h7, 1'b1);
    @(posedge clk);
    #1;
    total++;
    if (bus.ans !== 4'h0 || bus.ovf !== 1'b0) begin
      bad++;
      $display("[TB] FAIL async_hold got ans=%h ovf=%b want 0 0", bus.ans, bus.ovf);
    end
    @(negedge clk);
    rstN = 1'b1;
    @(posedge clk);
    #1;
    total++;
    if (bus.ans !== 4'h2 || bus.ovf !== 1'b1 || bus.cy_br_out !== 1'b0) begin
      bad++;
      $display("[TB] FAIL async_release got ans=%h cy=%b ovf=%b want 2 0 1",
               bus.ans, bus.cy_br_out, bus.ovf);
    end
  endtask

  task automatic test_directed();
    logic [14:0] v;
    for (int i = 0; i < 12; i++) begin
      v = getVec(i);
      @(negedge clk);
      applyStimulus(v[14:11], v[10:7], v[6]);
      @(posedge clk);
      #1;
      // Mid-cycle input change must not disturb the registered outputs.
      applyStimulus(~v[14:11], ~v[10:7], ~v[6]);
      #2;
      total++;
      if (bus.ans !== v[5:2]) begin
        bad++;
        $display("[TB] FAIL dir%0d_ans got %h want %h", i, bus.ans, v[5:2]);
      end
      total++;
      if (bus.cy_br_out !== v[1]) begin
        bad++;
        $display("[TB] FAIL dir%0d_cy got %b want %b", i, bus.cy_br_out, v[1]);
      end
      total++;
      if (bus.ovf !== v[0]) begin
        bad++;
        $display("[TB] FAIL dir%0d_ovf got %b want %b", i, bus.ovf, v[0]);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [14:0] v;
    logic [5:0]  want;
    logic [5:0]  got;
    want = '0;
    for (int i = 0; i <= 12; i++) begin
      @(negedge clk);
      if (i > 0) begin
        got = {bus.ans, bus.cy_br_out, bus.ovf};
        total++;
        if (got !== want) begin
          bad++;
          $display("[TB] FAIL b2b%0d got %h want %h", i - 1, got, want);
        end
      end
      if (i < 12) begin
        v = getVec(i);
        applyStimulus(v[14:11], v[10:7], v[6]);
        want = v[5:0];
      end
    end
  endtask

  task automatic test_exhaustive();
    logic [5:0] want;
    logic [5:0] got;
    logic [8:0] idxBits;
    want = '0;
    for (int i = 0; i <= 512; i++) begin
      @(negedge clk);
      if (i > 0) begin
        got = {bus.ans, bus.cy_br_out, bus.ovf};
        total++;
        if (got !== want) begin
          bad++;
          $display("[TB] FAIL sweep idx=%0d got %h want %h", i - 1, got, want);
        end
      end
      if (i < 512) begin
        idxBits = 9'(i);
        applyStimulus(idxBits[8:5], idxBits[4:1], idxBits[0]);
        want = refModel(idxBits[8:5], idxBits[4:1], idxBits[0]);
      end
    end
  endtask

  initial begin
    total = 0;
    bad   = 0;
    rstN  = 1'b0;
    applyStimulus(4'h0, 4'h0, 1'b0);
    test_reset();
    test_async_reset();
    test_directed();
    test_back_to_back();
    test_exhaustive();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
